round_sequencer: RTL and testbench

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/tow_pkg.sv | 33 +++
 rtl/btn_sync.sv | 32 +++
 rtl/round_sequencer.sv | 145 ++++++++++++++
 tb/tb_round_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war round sequencer: state encoding,
// terminal score patterns and the start-delay LFSR.
package tow_pkg;

   typedef enum logic [2:0] {
      ST_ARM   = 3'd0,
      ST_DELAY = 3'd1,
      ST_LIT   = 3'd2,
      ST_SCORE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } tow_state_e;

   // Scorer patterns that end the game: left win, right win, error.
   localparam logic [6:0] WIN_L = 7'b1110000;
   localparam logic [6:0] WIN_R = 7'b0000111;
   localparam logic [6:0] ERR   = 7'b1010101;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

   // Shift left, feed the XOR of the tapped bits into bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

   // True when the scorer shows a pattern that finishes the game.
   function automatic logic is_final(input logic [6:0] score);
      return (score == WIN_L) || (score == WIN_R) || (score == ERR);
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous push-button followed by a
// rising-edge detector. level_o is the synchronized level; edge_o is high
// for exactly one cycle when level_o goes from 0 to 1.
module btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic edge_o
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   // Synchronizer chain plus one delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= btn_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign edge_o  = s2_q & ~prev_q;

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer for a two-player reaction game. A round waits for both
// buttons to be released, waits a pseudo-random delay with the start
// lights off, lights them, and accepts the first push edge (which may come
// early, during the delay). The accepted push is reported with a one-cycle
// winrnd pulse plus right/tie qualifiers, followed by a hold-off after
// which the scorer output decides whether the game is over.
//
// Output protocol: winrnd is a single-cycle pulse with no back-pressure.
// right and tie are valid whenever winrnd is high and stay stable until
// the next accepted push. leds_on during the winrnd cycle tells the scorer
// whether the push came after the lights were lit.
module round_sequencer
   import tow_pkg::*;
#(
   parameter int unsigned MIN_DLY  = 16,
   parameter int unsigned DLY_BITS = 8,
   parameter int unsigned HOLD_CYC = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pbl,
   input  logic       pbr,
   input  logic [6:0] score,
   output logic       leds_on,
   output logic       winrnd,
   output logic       right,
   output logic       tie,
   output logic [2:0] state_o
);

   // 9 bits hold MIN_DLY + max addend (255 + 255) without wrapping.
   localparam int unsigned CNT_W = 9;

   tow_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]      lfsr_q;
   logic [15:0]      lfsr_d;
   logic [CNT_W-1:0] dly_load_d;
   logic             leds_on_q;
   logic             winrnd_q;
   logic             right_q;
   logic             tie_q;

   logic lvl_l, lvl_r;
   logic edge_l, edge_r;
   logic any_edge;

   btn_sync u_sync_l (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (pbl),
      .level_o (lvl_l),
      .edge_o  (edge_l)
   );

   btn_sync u_sync_r (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (pbr),
      .level_o (lvl_r),
      .edge_o  (edge_r)
   );

   assign any_edge   = edge_l | edge_r;
   assign lfsr_d     = lfsr_next(lfsr_q);
   assign dly_load_d = CNT_W'(MIN_DLY) +
                       {{(CNT_W-DLY_BITS){1'b0}}, lfsr_q[DLY_BITS-1:0]};

   // Free-running LFSR; never zero because it starts from a nonzero seed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end

   // Round FSM with registered outputs. Push edges are only honoured in
   // DELAY and LIT; all other states ignore them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ARM;
         cnt_q     <= '0;
         leds_on_q <= 1'b0;
         winrnd_q  <= 1'b0;
         right_q   <= 1'b0;
         tie_q     <= 1'b0;
      end else begin
         winrnd_q <= 1'b0;
         case (state_q)
            ST_ARM: begin
               leds_on_q <= 1'b0;
               // A held button must be released before a new round starts.
               if (!lvl_l && !lvl_r) begin
                  state_q <= ST_DELAY;
                  cnt_q   <= dly_load_d;
               end
            end
            ST_DELAY: begin
               if (any_edge) begin
                  // Early push: lights stay off so the scorer sees a foul.
                  state_q  <= ST_SCORE;
                  winrnd_q <= 1'b1;
                  right_q  <= edge_r & ~edge_l;
                  tie_q    <= edge_r & edge_l;
               end else if (cnt_q == '0) begin
                  state_q   <= ST_LIT;
                  leds_on_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_LIT: begin
               if (any_edge) begin
                  state_q  <= ST_SCORE;
                  winrnd_q <= 1'b1;
                  right_q  <= edge_r & ~edge_l;
                  tie_q    <= edge_r & edge_l;
               end
            end
            ST_SCORE: begin
               state_q   <= ST_HOLD;
               cnt_q     <= CNT_W'(HOLD_CYC - 1);
               leds_on_q <= 1'b0;
            end
            ST_HOLD: begin
               leds_on_q <= 1'b0;
               if (cnt_q == '0) state_q <= is_final(score) ? ST_DONE : ST_ARM;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            ST_DONE: begin
               leds_on_q <= 1'b0;
            end
            default: begin
               state_q   <= ST_ARM;
               leds_on_q <= 1'b0;
            end
         endcase
      end
   end

   assign leds_on = leds_on_q;
   assign winrnd  = winrnd_q;
   assign right   = right_q;
   assign tie     = tie_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer with a short delay and hold-off.
module tb_round_sequencer;
   import tow_pkg::*;

   localparam int MIN_DLY  = 4;
   localparam int DLY_BITS = 2;
   localparam int HOLD_CYC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pbl = 1'b0;
   logic       pbr = 1'b0;
   logic [6:0] score = 7'b0001000;
   logic       leds_on, winrnd, right, tie;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_fail   = 0;

   // {right, tie, leds_on} expected for each accepted push
   logic [2:0] exp_q[$];

   round_sequencer #(
      .MIN_DLY  (MIN_DLY),
      .DLY_BITS (DLY_BITS),
      .HOLD_CYC (HOLD_CYC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pbl     (pbl),
      .pbr     (pbr),
      .score   (score),
      .leds_on (leds_on),
      .winrnd  (winrnd),
      .right   (right),
      .tie     (tie),
      .state_o (state_o)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every winrnd pulse must match the oldest expected push
   always @(negedge clk) begin
      if (!rst && winrnd) begin
         if (exp_q.size() == 0) chk("sb_unexpected_win", 32'd1, 32'd0);
         else chk("sb_result", {29'd0, right, tie, leds_on}, {29'd0, exp_q.pop_front()});
      end
   end

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (state_o == s) break;
      end
      if (k == budget) chk(tag, 32'(state_o), 32'(s));
   endtask

   // drive a push at a falling edge and queue the expected result
   task automatic push(input logic l, input logic r, input logic exp_leds);
      pbl = l;
      pbr = r;
      exp_q.push_back({r & ~l, l & r, exp_leds});
   endtask

   // count falling edges until winrnd is seen; records whether LIT was visited
   task automatic wait_win(input int budget, input string tag, output int cycles, output logic lit_seen);
      lit_seen = 1'b0;
      for (cycles = 1; cycles <= budget; cycles++) begin
         @(negedge clk);
         if (state_o == ST_LIT) lit_seen = 1'b1;
         if (winrnd) break;
      end
      if (cycles > budget) chk(tag, 32'd0, 32'd1);
   endtask

   initial begin
      int   cyc;
      logic lit;
      int   led_hits;

      // reset state
      @(negedge clk);
      chk("rst_state", 32'(state_o), 32'(ST_ARM));
      chk("rst_outs", {28'd0, leds_on, winrnd, right, tie}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("arm_to_delay", 32'(state_o), 32'(ST_DELAY));

      // right push after lights on: 3-edge latency, one-cycle pulse
      wait_state(ST_LIT, 40, "t1_wait_lit");
      push(1'b0, 1'b1, 1'b1);
      wait_win(10, "t1_wait_win", cyc, lit);
      chk("t1_latency", 32'(cyc), 32'd3);
      chk("t1_right", {31'd0, right}, 32'd1);
      pbr = 1'b0;
      @(negedge clk);
      chk("t1_pulse_width", {31'd0, winrnd}, 32'd0);
      chk("t1_in_hold", 32'(state_o), 32'(ST_HOLD));

      // early left push during the delay: foul, LIT never reached
      wait_state(ST_DELAY, 40, "t2_wait_delay");
      push(1'b1, 1'b0, 1'b0);
      wait_win(10, "t2_wait_win", cyc, lit);
      chk("t2_no_lit", {31'd0, lit}, 32'd0);
      chk("t2_leds_off", {31'd0, leds_on}, 32'd0);
      pbl = 1'b0;

      // simultaneous push: tie
      wait_state(ST_LIT, 40, "t3_wait_lit");
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(1'b1, 1'b1, 1'b1);
      wait_win(10, "t3_wait_win", cyc, lit);
      chk("t3_tie", {30'd0, tie, right}, 32'd2);
      pbl = 1'b0;
      pbr = 1'b0;

      // right held through hold-off: round blocked in ARM, no repeat win
      wait_state(ST_LIT, 40, "t4_wait_lit");
      push(1'b0, 1'b1, 1'b1);
      wait_win(10, "t4_wait_win", cyc, lit);
      repeat (HOLD_CYC + 6) @(negedge clk);
      chk("t4_stuck_arm", 32'(state_o), 32'(ST_ARM));
      chk("t4_right_stable", {30'd0, right, tie}, 32'd2);
      pbr = 1'b0;
      wait_state(ST_DELAY, 8, "t4_release_delay");

      // reset in the middle of LIT
      wait_state(ST_LIT, 40, "t5_wait_lit");
      rst = 1'b1;
      #1;
      chk("t5_async_outs", {28'd0, leds_on, winrnd, right, tie}, 32'd0);
      chk("t5_async_state", 32'(state_o), 32'(ST_ARM));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_delay_after_rst", 32'(state_o), 32'(ST_DELAY));

      // right-win pattern at end of hold: game over, pushes ignored
      score = WIN_R;
      wait_state(ST_LIT, 40, "t6_wait_lit");
      push(1'b1, 1'b0, 1'b1);
      wait_win(10, "t6_wait_win", cyc, lit);
      pbl = 1'b0;
      wait_state(ST_DONE, HOLD_CYC + 6, "t6_wait_done");
      chk("t6_done", 32'(state_o), 32'(ST_DONE));
      led_hits = 0;
      for (int i = 0; i < 6; i++) begin
         pbl = 1'($urandom_range(0, 1));
         pbr = 1'($urandom_range(0, 1));
         repeat ($urandom_range(3, 5)) begin
            @(negedge clk);
            if (leds_on) led_hits++;
         end
         pbl = 1'b0;
         pbr = 1'b0;
         repeat (3) @(negedge clk);
      end
      chk("t6_leds_off", 32'(led_hits), 32'd0);
      chk("t6_still_done", 32'(state_o), 32'(ST_DONE));

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // absolute time limit
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
